mpu_fault_unit: RTL and testbench
=================================

# mpu_fault_unit

Fault-capture peripheral directly downstream of the memory protection unit: consumes the MPU's per-access deny pulse and buffers each blocked access (address, byte strobes, fetch flag) in a small FIFO. Firmware on the picorv32 reads and pops the records through a native-bus slave port decoded at `BASE_ADDR`. The block also raises a level interrupt into the core while records are pending or the FIFO has overflowed.

## Interface
- `BASE_ADDR`, 32'h0200_0000, 16-byte aligned register window base; must lie outside SRAM (0–4 KiB).
- `FIFO_DEPTH`, 4, fault record slots; power of two, 2–16.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-high.
- `fault_valid` input 1: one-cycle pulse from the MPU per denied access.
- `fault_addr` input 32: byte address of the denied access.
- `fault_wstrb` input 4: write strobes of the denied access (0 = read).
- `fault_instr` input 1: denied access was an instruction fetch.
- `bus_valid` input 1: native-bus request.
- `bus_addr` input 32: byte address.
- `bus_wdata` input 32: write data.
- `bus_wstrb` input 4: write strobes; 0 = read.
- `bus_ready` output 1: one-cycle acknowledge.
- `bus_rdata` output 32: read data, valid with `bus_ready`.
- `irq` output 1: level interrupt to core.

## Operation
- Decode: hit when `bus_addr[31:4] == BASE_ADDR[31:4]`. A miss is never acknowledged.
- Registers (offset `bus_addr[3:2]`):
  - 0x0 STATUS (R): [0] not-empty, [1] overflow (sticky), [2] full, [8:4] occupancy. Writing 1 to bit 1 clears overflow; other bits are ignored on write.
  - 0x4 HEAD_ADDR (R): `fault_addr` of the oldest record; 0 when empty.
  - 0x8 HEAD_INFO (R): [3:0] wstrb, [4] instr; 0 when empty.
  - 0xC POP: a write with any nonzero strobe pops the head. A read returns the 16-bit saturating total fault count in [15:0].
- Writes to read-only offsets are acknowledged and have no effect.
- Push: `fault_valid` with FIFO not full writes a record at the write pointer.
- Push when full: the record is dropped, overflow is set, and the total count still increments.
- Pop when empty: acknowledged, no effect.
- Simultaneous push and pop: both take effect. Occupancy is unchanged, including when full (the push is accepted because the pop frees a slot).
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Occupancy is a separate counter, 0..FIFO_DEPTH.
- Total count saturates at 0xFFFF. It is cleared only by reset.

## Timing
- Reset values: `bus_ready`=0, `bus_rdata`=0, `irq`=0, FIFO empty, overflow=0, count=0.
- Slave FSM states:
  - IDLE → ACK when there is a hit and `bus_valid`.
  - ACK asserts `bus_ready` for exactly one cycle, then goes to WAIT.
  - WAIT returns to IDLE once `bus_valid` drops. This prevents a double acknowledge when the master holds `bus_valid`.
- Latency: `bus_ready` is high the cycle after `bus_valid` is first sampled on a hit. `bus_rdata` is registered and is 0 when `bus_ready` is low.
- Write side effects (pop, overflow clear) commit on the ACK cycle's clock edge.
- A fault arriving on the same edge as a STATUS read is not visible in that read.
- `fault_valid` is sampled every edge regardless of bus state. Back-to-back pulses each push.
- `irq` is registered: (not-empty | overflow), delayed one cycle from the state change.
- Async `reset` mid-transaction aborts the FSM to IDLE and empties the FIFO immediately. `bus_ready` falls without waiting for a clock.

## Configuration
- `MPU_FAULT_IRQ_EN` defined: `irq` is driven as described.
- `MPU_FAULT_IRQ_EN` undefined: `irq` is tied to 0 and its register is removed. Firmware polls STATUS; all other behaviour is identical.

## Test plan
- Single fault: pulse fault_addr=0x300, wstrb=0xF, instr=0 → STATUS reads 0x11, HEAD_ADDR=0x300, HEAD_INFO=0x0F, irq=1. After a POP write, STATUS=0 and irq=0.
- Overflow: 5 pulses with addresses 0x300..0x310 at FIFO_DEPTH=4 → STATUS=0x47. Heads pop in order 0x300, 0x304, 0x308, 0x30C. POP read returns 5. Writing STATUS=0x2 clears overflow.
- Simultaneous: FIFO full (4 records) with a fault pulse on the POP-commit edge → occupancy stays 4, overflow stays 0, and the new record is last out.
- Handshake: hold `bus_valid` for 6 cycles on a STATUS read → exactly one `bus_ready` pulse, 1 cycle after valid. An access to BASE_ADDR+0x10 never gets `bus_ready`.
- Saturation and reset: 65540 pulses → count reads 0xFFFF. Asserting `reset` mid-ACK → `bus_ready`=0, STATUS=0, count=0 immediately.

Source files
------------

// File: rtl/mpu_fault_unit.sv
// mpu_fault_unit: captures MPU-denied accesses into a small FIFO that firmware
// inspects and pops through a native-bus slave register window.
//
// Optional feature macro: MPU_FAULT_IRQ_EN (defined -> irq driven from a
// register; undefined -> irq tied low and its register removed).
//
// Ports:
//   clk, reset                 single clock, async active-high reset
//   fault_valid/addr/wstrb/instr  per-denied-access pulse and its attributes
//   bus_valid/addr/wdata/wstrb    native-bus slave request
//   bus_ready, bus_rdata          registered one-cycle acknowledge and read data
//   irq                           level interrupt: records pending or overflow
//
// Register window (bus_addr[3:2]):
//   0 STATUS    [0] not-empty [1] overflow (W1C) [2] full [8:4] occupancy
//   1 HEAD_ADDR address of oldest record, 0 when empty
//   2 HEAD_INFO [3:0] wstrb [4] instr, 0 when empty
//   3 POP       write pops head; read returns saturating fault count
module mpu_fault_unit #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fault_valid,
    input  logic [31:0] fault_addr,
    input  logic [3:0]  fault_wstrb,
    input  logic        fault_instr,
    input  logic        bus_valid,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wstrb,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic        irq
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_W = 16;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic        instr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
    } rec_t;

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       off_q, off_d;
    logic             wr_q, wr_d;
    logic             clr_q, clr_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rec_t             mem_q [FIFO_DEPTH];

    logic             hit_c, empty_c, full_c, commit_c, pop_c, clr_ovf_c, push_c;
    rec_t             head_c;
    logic [31:0]      status_c, rd_mux_c;
    logic             unused_ok_c;

    assign hit_c     = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign empty_c   = (occ_q == '0);
    assign full_c    = (occ_q == DEPTH_C);
    assign head_c    = mem_q[rd_ptr_q];

    // Write side effects commit on the edge that ends the ACK cycle.
    assign commit_c  = (state_q == ST_ACK) && wr_q;
    assign pop_c     = commit_c && (off_q == 2'd3) && !empty_c;
    assign clr_ovf_c = commit_c && (off_q == 2'd0) && clr_q;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign push_c    = fault_valid && (!full_c || pop_c);

    assign unused_ok_c = ^{bus_wdata[31:2], bus_wdata[0], bus_addr[1:0]};

    // Read mux, sampled on the edge entering ACK.
    always_comb begin
        status_c             = '0;
        status_c[0]          = !empty_c;
        status_c[1]          = ovf_q;
        status_c[2]          = full_c;
        status_c[4 +: OCC_W] = occ_q;
        rd_mux_c             = '0;
        case (bus_addr[3:2])
            2'd0:    rd_mux_c = status_c;
            2'd1:    rd_mux_c = empty_c ? 32'd0 : head_c.addr;
            2'd2:    rd_mux_c = empty_c ? 32'd0 : {27'd0, head_c.instr, head_c.wstrb};
            default: rd_mux_c = {16'd0, cnt_q};
        endcase
    end

    // Slave FSM next-state and registered outputs.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = '0;
        off_d   = off_q;
        wr_d    = wr_q;
        clr_d   = clr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_valid && hit_c) begin
                    state_d = ST_ACK;
                    ready_d = 1'b1;
                    rdata_d = rd_mux_c;
                    off_d   = bus_addr[3:2];
                    wr_d    = |bus_wstrb;
                    clr_d   = bus_wdata[1];
                end
            end
            ST_ACK:  state_d = ST_WAIT;
            // Hold off re-acknowledging until the master releases the request.
            ST_WAIT: if (!bus_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointers, occupancy, overflow and saturating fault count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_c, pop_c})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        // Set beats clear when both land on the same edge.
        if (clr_ovf_c) ovf_d = 1'b0;
        if (fault_valid && full_c && !pop_c) ovf_d = 1'b1;
        if (fault_valid && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            off_q    <= '0;
            wr_q     <= 1'b0;
            clr_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            off_q    <= off_d;
            wr_q     <= wr_d;
            clr_q    <= clr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Record storage; contents are don't-care while their slot is empty.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{instr: fault_instr, wstrb: fault_wstrb, addr: fault_addr};
        end
    end

    assign bus_ready = ready_q;
    assign bus_rdata = rdata_q;

`ifdef MPU_FAULT_IRQ_EN
    logic irq_q;

    // Interrupt follows the registered FIFO state one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= !empty_c || ovf_q;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mpu_fault_unit.sv
// Self-checking bench for mpu_fault_unit: directed scenarios plus randomized
// traffic compared against a queue-based model of the fault FIFO.
module tb_mpu_fault_unit;

    localparam logic [31:0] BASE  = 32'h0200_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fault_valid = 1'b0;
    logic [31:0] fault_addr = '0;
    logic [3:0]  fault_wstrb = '0;
    logic        fault_instr = 1'b0;
    logic        bus_valid = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [3:0]  bus_wstrb = '0;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        irq;

    mpu_fault_unit #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .fault_valid(fault_valid), .fault_addr(fault_addr),
        .fault_wstrb(fault_wstrb), .fault_instr(fault_instr),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: a queue of pending records, sticky overflow, count.
    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic        i;
    } rec_t;
    rec_t q[$];
    bit   ovf = 0;
    int   cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf = 0;
        cnt = 0;
    endtask

    task automatic model_fault(input logic [31:0] a, input logic [3:0] s, input logic i);
        rec_t r;
        r.a = a; r.s = s; r.i = i;
        if (q.size() < DEPTH) q.push_back(r);
        else ovf = 1;
        if (cnt < 65535) cnt++;
    endtask

    task automatic model_write(input logic [1:0] off, input logic [31:0] wd);
        if (off == 2'd3 && q.size() != 0) void'(q.pop_front());
        if (off == 2'd0 && wd[1]) ovf = 0;
    endtask

    function automatic logic [31:0] exp_read(input logic [1:0] off);
        int n;
        n = q.size();
        case (off)
            2'd0: return 32'((n * 16) + ((n == DEPTH) ? 4 : 0) + (ovf ? 2 : 0) + ((n != 0) ? 1 : 0));
            2'd1: return (n != 0) ? q[0].a : 32'd0;
            2'd2: return (n != 0) ? {27'd0, q[0].i, q[0].s} : 32'd0;
            default: return 32'(cnt);
        endcase
    endfunction

    function automatic logic [31:0] exp_irq();
`ifdef MPU_FAULT_IRQ_EN
        return ((q.size() != 0) || ovf) ? 32'd1 : 32'd0;
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus_valid = 1'b0;
        fault_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse(input logic [31:0] a, input logic [3:0] s, input logic i);
        @(negedge clk);
        fault_valid = 1'b1; fault_addr = a; fault_wstrb = s; fault_instr = i;
        @(negedge clk);
        fault_valid = 1'b0;
        model_fault(a, s, i);
    endtask

    // Back-to-back random fault pulses, one per cycle.
    task automatic burst(input int n);
        logic [31:0] a;
        logic [3:0]  s;
        logic        i;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            a = $urandom; s = 4'($urandom_range(0, 15)); i = 1'($urandom_range(0, 1));
            fault_valid = 1'b1; fault_addr = a; fault_wstrb = s; fault_instr = i;
            @(negedge clk);
            model_fault(a, s, i);
        end
        fault_valid = 1'b0;
    endtask

    // One bus access; optional fault on the request-sample edge or the commit edge.
    task automatic xfer(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                        input bit inj_s, input bit inj_c, input logic [31:0] inj_a,
                        output logic [31:0] rd);
        int n;
        bit got;
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = addr; bus_wstrb = ws; bus_wdata = wd;
        if (inj_s) begin
            fault_valid = 1'b1; fault_addr = inj_a; fault_wstrb = 4'hA; fault_instr = 1'b1;
        end
        @(negedge clk);
        n = 1;
        if (inj_s) begin
            fault_valid = 1'b0;
            model_fault(inj_a, 4'hA, 1'b1);
        end
        while (!bus_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        got = bus_ready;
        check("ack_latency", 32'(n), 32'd1);
        rd = bus_rdata;
        bus_valid = 1'b0; bus_wstrb = 4'h0;
        if (inj_c) begin
            fault_valid = 1'b1; fault_addr = inj_a; fault_wstrb = 4'hA; fault_instr = 1'b1;
        end
        @(negedge clk);
        fault_valid = 1'b0;
        check("ack_single_cycle", 32'(bus_ready), 32'd0);
        if (got && ws != 4'h0) model_write(addr[3:2], wd);
        if (inj_c) model_fault(inj_a, 4'hA, 1'b1);
        @(negedge clk);
        check("irq_level", 32'(irq), exp_irq());
    endtask

    task automatic rd_check(input string tag, input logic [1:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        xfer(BASE + 32'(off) * 4, 4'h0, 32'd0, 0, 0, 32'd0, rd);
        check(tag, rd, exp);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] rd;
        xfer(BASE + 32'(off) * 4, 4'hF, wd, 0, 0, 32'd0, rd);
    endtask

    task automatic hold_count(input logic [31:0] addr, input logic [3:0] ws,
                              output int nrdy, output int first);
        nrdy = 0; first = -1;
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = addr; bus_wstrb = ws; bus_wdata = 32'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus_ready) begin
                nrdy++;
                if (first < 0) first = k;
            end
        end
        bus_valid = 1'b0; bus_wstrb = 4'h0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        int nrdy, first, op;
        logic [1:0] off;

        // Reset values
        #1 reset = 1'b1;
        #1;
        check("rst_ready", 32'(bus_ready), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Single fault
        pulse(32'h300, 4'hF, 1'b0);
        rd_check("single_status", 2'd0, 32'h11);
        rd_check("single_head_addr", 2'd1, 32'h300);
        rd_check("single_head_info", 2'd2, 32'h0F);
        check("single_irq", 32'(irq), exp_irq());
        wr(2'd3, 32'd0);
        rd_check("single_status_after_pop", 2'd0, 32'h0);
        check("single_irq_after_pop", 32'(irq), 32'd0);

        // Overflow
        do_reset();
        for (int k = 0; k < 5; k++) pulse(32'h300 + 32'(k) * 4, 4'h0, 1'b0);
        rd_check("ovf_status", 2'd0, 32'h47);
        for (int k = 0; k < 4; k++) begin
            rd_check("ovf_pop_order", 2'd1, 32'h300 + 32'(k) * 4);
            wr(2'd3, 32'd0);
        end
        rd_check("ovf_count", 2'd3, 32'd5);
        rd_check("ovf_status_drained", 2'd0, 32'h02);
        wr(2'd0, 32'h2);
        rd_check("ovf_cleared", 2'd0, 32'h0);

        // Simultaneous push and pop while full
        for (int k = 0; k < 4; k++) pulse(32'h400 + 32'(k) * 4, 4'h1, 1'b0);
        xfer(BASE + 32'hC, 4'h1, 32'd0, 0, 1, 32'h500, rd);
        rd_check("simul_status", 2'd0, 32'h45);
        for (int k = 0; k < 4; k++) begin
            rd_check("simul_order", 2'd1, (k == 3) ? 32'h500 : 32'h404 + 32'(k) * 4);
            wr(2'd3, 32'd0);
        end

        // Fault on the same edge as a STATUS read is not in that read
        xfer(BASE, 4'h0, 32'd0, 1, 0, 32'h600, rd);
        check("same_edge_read", rd, 32'h0);
        rd_check("same_edge_after", 2'd0, 32'h11);
        wr(2'd1, 32'hFFFF_FFFF);
        rd_check("ro_write_ignored", 2'd1, 32'h600);

        // Handshake: held valid gives one ready; window+0x10 never acknowledged
        hold_count(BASE, 4'h0, nrdy, first);
        check("hold_ready_pulses", 32'(nrdy), 32'd1);
        check("hold_ready_latency", 32'(first), 32'd1);
        hold_count(BASE + 32'h10, 4'h0, nrdy, first);
        check("miss_no_ready", 32'(nrdy), 32'd0);
        hold_count(BASE + 32'h1C, 4'hF, nrdy, first);
        check("miss_pop_no_ready", 32'(nrdy), 32'd0);
        rd_check("miss_pop_no_effect", 2'd0, 32'h11);

        // Randomized traffic against the model
        do_reset();
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 6);
            off = 2'($urandom_range(0, 3));
            case (op)
                0, 1: burst($urandom_range(1, 3));
                2: begin
                    exp = exp_read(off);
                    xfer(BASE + 32'(off) * 4, 4'h0, 32'd0, 0, 0, 32'd0, rd);
                    check("rand_read", rd, exp);
                end
                3: xfer(BASE + 32'($urandom_range(1, 3)) * 4, 4'($urandom_range(1, 15)),
                        $urandom, 0, 0, 32'd0, rd);
                4: xfer(BASE, 4'hF, $urandom, 0, 0, 32'd0, rd);
                5: begin
                    exp = exp_read(2'd0);
                    xfer(BASE, 4'h0, 32'd0, 1, 0, $urandom, rd);
                    check("rand_status_same_edge", rd, exp);
                end
                default: xfer(BASE + 32'hC, 4'hF, 32'd0, 0, 1, $urandom, rd);
            endcase
        end
        for (int k = 0; k < 4; k++) begin
            exp = exp_read(2'(k));
            xfer(BASE + 32'(k) * 4, 4'h0, 32'd0, 0, 0, 32'd0, rd);
            check("rand_final_read", rd, exp);
        end

        // Saturation
        do_reset();
        burst(65540);
        rd_check("sat_count", 2'd3, 32'hFFFF);
        rd_check("sat_count_model", 2'd3, exp_read(2'd3));
        rd_check("sat_status", 2'd0, 32'h47);

        // Async reset in the middle of an acknowledge
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = BASE; bus_wstrb = 4'h0;
        @(negedge clk);
        check("mid_ack_ready", 32'(bus_ready), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_ready_immediate", 32'(bus_ready), 32'd0);
        check("reset_rdata_immediate", bus_rdata, 32'd0);
        check("reset_irq_immediate", 32'(irq), 32'd0);
        @(negedge clk);
        bus_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        rd_check("reset_status", 2'd0, 32'h0);
        rd_check("reset_count", 2'd3, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
